sap_control_sequencer: RTL and testbench

- Fetch/decode/execute control unit for the 16-bit SAP datapath.
- Initiator side of the program-counter interface: drives pc_inc, pc_write and pc_out_en, and sequences the bus transfers between PC, MAR, RAM, IR, A, B, ALU and OUT.
- A step counter advances one step per clk; the control word is decoded from the current step, ir_opcode and the flags.

---
 rtl/sap_control_sequencer.sv | 173 +++++++++++++++++
 tb/tb_sap_control_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer.sv
// Fetch/decode/execute control sequencer for the 16-bit SAP datapath.
// Define SEQ_EARLY_FETCH_EN for variable-length instructions (early return to T0).
module sap_control_sequencer #(
  parameter int unsigned STEP_W    = 3,
  parameter int unsigned LAST_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        ir_opcode,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic              pc_out_en,
  output logic              pc_inc,
  output logic              pc_write,
  output logic              mar_load,
  output logic              ram_out_en,
  output logic              ram_load,
  output logic              ir_load,
  output logic              ir_out_en,
  output logic              a_load,
  output logic              a_out_en,
  output logic              b_load,
  output logic              alu_out_en,
  output logic              alu_sub,
  output logic              flag_load,
  output logic              out_load,
  output logic              halt,
  output logic [STEP_W-1:0] step
);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [STEP_W-1:0] step_q, step_d, last_step;
  logic              halted_q, halted_d;

  assign step = step_q;

  // Final active step of the current instruction
  always_comb begin
    last_step = STEP_W'(LAST_STEP);
`ifdef SEQ_EARLY_FETCH_EN
    case (ir_opcode)
      OP_LDA, OP_STA: last_step = STEP_W'(3);
      OP_ADD, OP_SUB: last_step = STEP_W'(4);
      default:        last_step = STEP_W'(2);
    endcase
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Next state: HLT freezes at T2, otherwise advance or wrap to fetch
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (step_q == STEP_W'(2) && ir_opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else if (step_q >= last_step) begin
        step_d = '0;
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end
  end

  // Control word decode
  always_comb begin
    pc_out_en  = 1'b0;
    pc_inc     = 1'b0;
    pc_write   = 1'b0;
    mar_load   = 1'b0;
    ram_out_en = 1'b0;
    ram_load   = 1'b0;
    ir_load    = 1'b0;
    ir_out_en  = 1'b0;
    a_load     = 1'b0;
    a_out_en   = 1'b0;
    b_load     = 1'b0;
    alu_out_en = 1'b0;
    alu_sub    = 1'b0;
    flag_load  = 1'b0;
    out_load   = 1'b0;
    halt       = halted_q & ~rst;
    if (!rst && !halted_q) begin
      case (step_q)
        STEP_W'(0): begin
          pc_out_en = 1'b1;
          mar_load  = 1'b1;
        end
        STEP_W'(1): begin
          ram_out_en = 1'b1;
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
        end
        STEP_W'(2): begin
          case (ir_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out_en = 1'b1;
              mar_load  = 1'b1;
            end
            OP_LDI: begin
              ir_out_en = 1'b1;
              a_load    = 1'b1;
            end
            OP_JMP: begin
              ir_out_en = 1'b1;
              pc_write  = 1'b1;
            end
            OP_JC: begin
              ir_out_en = flag_c;
              pc_write  = flag_c;
            end
            OP_JZ: begin
              ir_out_en = flag_z;
              pc_write  = flag_z;
            end
            OP_OUT: begin
              a_out_en = 1'b1;
              out_load = 1'b1;
            end
            default: ;
          endcase
        end
        STEP_W'(3): begin
          case (ir_opcode)
            OP_LDA: begin
              ram_out_en = 1'b1;
              a_load     = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_out_en = 1'b1;
              b_load     = 1'b1;
            end
            OP_STA: begin
              a_out_en = 1'b1;
              ram_load = 1'b1;
            end
            default: ;
          endcase
        end
        STEP_W'(4): begin
          if (ir_opcode == OP_ADD || ir_opcode == OP_SUB) begin
            alu_out_en = 1'b1;
            a_load     = 1'b1;
            flag_load  = 1'b1;
            alu_sub    = (ir_opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Randomized bench for sap_control_sequencer against an instruction-level model.
// Build with +define+SEQ_EARLY_FETCH_EN to check the variable-length variant.
module tb_sap_control_sequencer;

  localparam logic [15:0] M_PC_OUT  = 16'h0001;
  localparam logic [15:0] M_PC_INC  = 16'h0002;
  localparam logic [15:0] M_PC_WR   = 16'h0004;
  localparam logic [15:0] M_MAR     = 16'h0008;
  localparam logic [15:0] M_RAM_OUT = 16'h0010;
  localparam logic [15:0] M_RAM_LD  = 16'h0020;
  localparam logic [15:0] M_IR_LD   = 16'h0040;
  localparam logic [15:0] M_IR_OUT  = 16'h0080;
  localparam logic [15:0] M_A_LD    = 16'h0100;
  localparam logic [15:0] M_A_OUT   = 16'h0200;
  localparam logic [15:0] M_B_LD    = 16'h0400;
  localparam logic [15:0] M_ALU_OUT = 16'h0800;
  localparam logic [15:0] M_SUB     = 16'h1000;
  localparam logic [15:0] M_FLAG    = 16'h2000;
  localparam logic [15:0] M_OUT     = 16'h4000;
  localparam logic [15:0] M_HALT    = 16'h8000;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] op;
  logic fc, fz;
  logic pc_out_en, pc_inc, pc_write, mar_load, ram_out_en, ram_load, ir_load, ir_out_en;
  logic a_load, a_out_en, b_load, alu_out_en, alu_sub, flag_load, out_load, halt;
  logic [2:0] step;
  logic [15:0] act;

  int vectors = 0;
  int miscompares = 0;
  int m_step = 0;
  bit m_halt = 1'b0;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  sap_control_sequencer dut (
    .clk(clk), .rst(rst), .ir_opcode(op), .flag_c(fc), .flag_z(fz),
    .pc_out_en(pc_out_en), .pc_inc(pc_inc), .pc_write(pc_write), .mar_load(mar_load),
    .ram_out_en(ram_out_en), .ram_load(ram_load), .ir_load(ir_load), .ir_out_en(ir_out_en),
    .a_load(a_load), .a_out_en(a_out_en), .b_load(b_load), .alu_out_en(alu_out_en),
    .alu_sub(alu_sub), .flag_load(flag_load), .out_load(out_load), .halt(halt), .step(step)
  );

  assign act = {halt, out_load, flag_load, alu_sub, alu_out_en, b_load, a_out_en, a_load,
                ir_out_en, ir_load, ram_load, ram_out_en, mar_load, pc_write, pc_inc, pc_out_en};

  task automatic chk(input string name, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, a, e);
    end
  endtask

  // Number of steps an instruction occupies
  function automatic int ilen(input int o);
`ifdef SEQ_EARLY_FETCH_EN
    if (o == 1 || o == 4) return 4;
    if (o == 2 || o == 3) return 5;
    return 3;
`else
    return 5;
`endif
  endfunction

  // Instruction table: what the datapath must do in each step
  function automatic logic [15:0] exp_ctrl(input int s, input int o, input bit c, input bit z,
                                           input bit r, input bit h);
    if (r) return 16'h0;
    if (h) return M_HALT;
    if (s == 0) return M_PC_OUT | M_MAR;
    if (s == 1) return M_RAM_OUT | M_IR_LD | M_PC_INC;
    case (o)
      1: return (s == 2) ? (M_IR_OUT | M_MAR) : (s == 3) ? (M_RAM_OUT | M_A_LD) : 16'h0;
      2, 3: begin
        if (s == 2) return M_IR_OUT | M_MAR;
        if (s == 3) return M_RAM_OUT | M_B_LD;
        return M_ALU_OUT | M_A_LD | M_FLAG | ((o == 3) ? M_SUB : 16'h0);
      end
      4: return (s == 2) ? (M_IR_OUT | M_MAR) : (s == 3) ? (M_A_OUT | M_RAM_LD) : 16'h0;
      5: return (s == 2) ? (M_IR_OUT | M_A_LD) : 16'h0;
      6: return (s == 2) ? (M_IR_OUT | M_PC_WR) : 16'h0;
      7: return (s == 2 && c) ? (M_IR_OUT | M_PC_WR) : 16'h0;
      8: return (s == 2 && z) ? (M_IR_OUT | M_PC_WR) : 16'h0;
      14: return (s == 2) ? (M_A_OUT | M_OUT) : 16'h0;
      default: return 16'h0;
    endcase
  endfunction

  // Instruction-level model of step/halt progression
  always @(posedge clk) begin
    if (rst) begin
      m_step = 0;
      m_halt = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid && !m_halt) begin
      if (m_step == 2 && op == 4'hF) m_halt = 1'b1;
      else if (m_step + 1 >= ilen(int'(op))) m_step = 0;
      else m_step = m_step + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("ctrl", int'(act), int'(exp_ctrl(m_step, int'(op), fc, fz, rst, m_halt)));
      chk("step", int'(step), m_step);
      chk("bus_drivers", int'($countones({pc_out_en, ram_out_en, ir_out_en, a_out_en, alu_out_en}) <= 1), 1);
      chk("pc_inc_write", int'(pc_inc & pc_write), 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_step(input int n);
    int k = 0;
    while (int'(step) != n && k < 12) begin
      cyc();
      k++;
    end
    if (int'(step) != n) chk("wait_step_timeout", int'(step), n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op = 4'h2; fc = 1'b0; fz = 1'b0;
    cyc();
    @(negedge clk); chk("rst_ctrl", int'(act), 0); chk("rst_step", int'(step), 0);
    cyc(); rst = 1'b0;
    // ADD: fetch then T2..T4, wrapping to T0
    @(negedge clk); chk("t0_ctrl", int'(act), int'(M_PC_OUT | M_MAR));
    cyc(); @(negedge clk); chk("t1_step", int'(step), 1);
    chk("t1_ctrl", int'(act), int'(M_RAM_OUT | M_IR_LD | M_PC_INC));
    cyc(); @(negedge clk); chk("add_t2", int'(act), int'(M_IR_OUT | M_MAR));
    cyc(); @(negedge clk); chk("add_t3", int'(act), int'(M_RAM_OUT | M_B_LD));
    cyc(); @(negedge clk); chk("add_t4", int'(act), int'(M_ALU_OUT | M_A_LD | M_FLAG));
    chk("add_t4_step", int'(step), 4);
    cyc(); @(negedge clk); chk("wrap_step", int'(step), 0);
    cyc();
    // SUB
    wait_step(0); op = 4'h3;
    wait_step(3); @(negedge clk); chk("sub_t3", int'(act), int'(M_RAM_OUT | M_B_LD));
    wait_step(4); @(negedge clk); chk("sub_t4", int'(act), int'(M_ALU_OUT | M_A_LD | M_FLAG | M_SUB));
    // JC untaken then taken
    wait_step(0); op = 4'h7; fc = 1'b0;
    wait_step(2); @(negedge clk); chk("jc_nt", int'(act), 0);
    wait_step(0); fc = 1'b1;
    wait_step(2); @(negedge clk); chk("jc_t", int'(act), int'(M_IR_OUT | M_PC_WR));
    // JZ ignores carry
    wait_step(0); op = 4'h8; fz = 1'b0;
    wait_step(2); @(negedge clk); chk("jz_nt", int'(act), 0);
    wait_step(0); fz = 1'b1;
    wait_step(2); @(negedge clk); chk("jz_t", int'(act), int'(M_IR_OUT | M_PC_WR));
    // HLT holds until reset
    wait_step(0); op = 4'hF;
    wait_step(2); cyc();
    repeat (20) begin
      @(negedge clk); chk("halt_ctrl", int'(act), int'(M_HALT)); chk("halt_step", int'(step), 2);
      cyc();
    end
    rst = 1'b1;
    @(negedge clk); chk("halt_rst_ctrl", int'(act), 0);
    cyc(); rst = 1'b0; op = 4'h1;
    @(negedge clk); chk("post_halt_step", int'(step), 0);
    chk("post_halt_ctrl", int'(act), int'(M_PC_OUT | M_MAR));
    // Reset during LDA T3 abandons the load
    wait_step(3); rst = 1'b1;
    @(negedge clk); chk("lda_rst_ctrl", int'(act), 0);
    cyc(); rst = 1'b0; op = 4'h0;
    @(negedge clk); chk("lda_rst_step", int'(step), 0);
    chk("lda_rst_t0", int'(act), int'(M_PC_OUT | M_MAR));
    // LDI length
    wait_step(0); op = 4'h5;
    cyc(); cyc();
    @(negedge clk); chk("ldi_t2", int'(act), int'(M_IR_OUT | M_A_LD));
    cyc(); @(negedge clk);
`ifdef SEQ_EARLY_FETCH_EN
    chk("ldi_next_step", int'(step), 0);
`else
    chk("ldi_next_step", int'(step), 3);
`endif
    // Random instruction stream with occasional resets
    repeat (3000) begin
      cyc();
      if (m_step == 0 && !m_halt) op = 4'($urandom_range(0, 15));
      fc = 1'($urandom);
      fz = 1'($urandom);
      rst = ($urandom_range(0, 39) == 0);
    end
    cyc(); rst = 1'b0;
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
